aes_encrypt_controller: RTL and testbench

//  Sequencing FSM for AES-128 encryption; the forward counterpart of the decryption controller.

---
 rtl/aes_encrypt_controller.sv | 160 ++++++++++++++++
 tb/tb_aes_encrypt_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_controller.sv
// ============================================================================
// Module  : aes_encrypt_controller
// Purpose : Sequences AES-128 encryption rounds over an external datapath and
//           fetches round keys 0..NUM_ROUNDS from the key schedule.
// Options : AES_ENC_ABORT_EN adds the abort input and aborted output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_encrypt_controller #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic         key_ack,
    input  logic [127:0] dp_result,
`ifdef AES_ENC_ABORT_EN
    input  logic         abort,
    output logic         aborted,
`endif
    output logic         key_req,
    output logic [3:0]   key_round,
    output logic [127:0] state_out,
    output logic         sub_bytes_enable,
    output logic         shift_rows_enable,
    output logic         mix_cols_enable,
    output logic         add_round_key_enable,
    output logic         busy,
    output logic         done,
    output logic [127:0] cipher_out
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_KEY_WAIT = 3'd2,
        S_ROUND    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t       fsm_state;
    state_t       fsm_next;
    logic [3:0]   round;
    logic [3:0]   round_next;
    logic [127:0] state_reg;
    logic [127:0] state_reg_next;
    logic [127:0] cipher_reg;
    logic [127:0] cipher_next;
    logic         abort_hit;

`ifdef AES_ENC_ABORT_EN
    logic aborted_reg;

    assign abort_hit = abort && (fsm_state != S_IDLE);
    assign aborted   = aborted_reg;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_state  <= S_IDLE;
            round      <= 4'd0;
            state_reg  <= 128'd0;
            cipher_reg <= 128'd0;
        end else begin
            fsm_state  <= fsm_next;
            round      <= round_next;
            state_reg  <= state_reg_next;
            cipher_reg <= cipher_next;
        end
    end

`ifdef AES_ENC_ABORT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            aborted_reg <= 1'b0;
        end else begin
            aborted_reg <= abort_hit;
        end
    end
`endif

    always_comb begin
        fsm_next       = fsm_state;
        round_next     = round;
        state_reg_next = state_reg;
        cipher_next    = cipher_reg;
        case (fsm_state)
            S_IDLE: begin
                if (start) begin
                    fsm_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_reg_next = data_in;
                round_next     = 4'd0;
                fsm_next       = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                if (key_ack) begin
                    fsm_next = S_ROUND;
                end
            end
            S_ROUND: begin
                state_reg_next = dp_result;
                if (round >= LAST_ROUND) begin
                    fsm_next = S_DONE;
                end else begin
                    round_next = round + 4'd1;
                    fsm_next   = S_KEY_WAIT;
                end
            end
            S_DONE: begin
                cipher_next = state_reg;
                fsm_next    = S_IDLE;
            end
            default: begin
                fsm_next = S_IDLE;
            end
        endcase
        // Abort overrides every transition and leaves the previous ciphertext intact.
        if (abort_hit) begin
            fsm_next       = S_IDLE;
            round_next     = 4'd0;
            state_reg_next = 128'd0;
            cipher_next    = cipher_reg;
        end
    end

    always_comb begin
        sub_bytes_enable     = 1'b0;
        shift_rows_enable    = 1'b0;
        mix_cols_enable      = 1'b0;
        add_round_key_enable = 1'b0;
        if (fsm_state == S_ROUND) begin
            add_round_key_enable = 1'b1;
            if (round != 4'd0) begin
                sub_bytes_enable  = 1'b1;
                shift_rows_enable = 1'b1;
                mix_cols_enable   = (round != LAST_ROUND);
            end
        end
    end

    // The ciphertext is presented straight from state_reg during DONE so it is valid with done.
    assign key_req    = (fsm_state == S_KEY_WAIT);
    assign key_round  = round;
    assign state_out  = state_reg;
    assign busy       = (fsm_state != S_IDLE);
    assign done       = (fsm_state == S_DONE) && !abort_hit;
    assign cipher_out = done ? state_reg : cipher_reg;

endmodule

`default_nettype wire

// File: tb/tb_aes_encrypt_controller.sv
// Testbench for aes_encrypt_controller; models the AES round datapath and key schedule.
`default_nettype none

module tb_aes_encrypt_controller;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [127:0] data_in;
    logic         key_ack;
    logic [127:0] dp_result;
    logic         key_req;
    logic [3:0]   key_round;
    logic [127:0] state_out;
    logic         sub_bytes_enable;
    logic         shift_rows_enable;
    logic         mix_cols_enable;
    logic         add_round_key_enable;
    logic         busy;
    logic         done;
    logic [127:0] cipher_out;
`ifdef AES_ENC_ABORT_EN
    logic         abort;
    logic         aborted;
`endif

    always #5 clk = ~clk;

    aes_encrypt_controller #(.NUM_ROUNDS(10)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .start                (start),
        .data_in              (data_in),
        .key_ack              (key_ack),
        .dp_result            (dp_result),
`ifdef AES_ENC_ABORT_EN
        .abort                (abort),
        .aborted              (aborted),
`endif
        .key_req              (key_req),
        .key_round            (key_round),
        .state_out            (state_out),
        .sub_bytes_enable     (sub_bytes_enable),
        .shift_rows_enable    (shift_rows_enable),
        .mix_cols_enable      (mix_cols_enable),
        .add_round_key_enable (add_round_key_enable),
        .busy                 (busy),
        .done                 (done),
        .cipher_out           (cipher_out)
    );

    logic [2047:0] sbox_bits = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic [127:0] rk [0:15];

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_bits[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] b, input int i);
        return b[127 - 8 * i -: 8];
    endfunction

    function automatic logic [127:0] sub_blk(input logic [127:0] b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = sb(gb(b, i));
        return r;
    endfunction

    function automatic logic [127:0] shift_blk(input logic [127:0] b);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127 - 8 * (w + 4 * c) -: 8] = gb(b, w + 4 * ((c + w) % 4));
        return r;
    endfunction

    function automatic logic [127:0] mix_blk(input logic [127:0] b);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(b, 4 * c);     a1 = gb(b, 4 * c + 1);
            a2 = gb(b, 4 * c + 2); a3 = gb(b, 4 * c + 3);
            r[127 - 32 * c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return r;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r < 11) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : 128'd0;
    endtask

    always_comb begin
        dp_result = state_out;
        if (sub_bytes_enable)     dp_result = sub_blk(dp_result);
        if (shift_rows_enable)    dp_result = shift_blk(dp_result);
        if (mix_cols_enable)      dp_result = mix_blk(dp_result);
        if (add_round_key_enable) dp_result = dp_result ^ rk[key_round];
    end

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        int           delay;
        int           lat;
        bit           repulse;
    } vec_t;

    vec_t       vecs [4];
    logic [3:0] exp_en [0:15];
    int n_cmp = 0;
    int n_bad = 0;
    int cur_delay = 0;
    int wait_cnt = 0;
    int ena_cycles = 0;
    int kreq_cycles = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One clock: advance past the edge, then sample outputs and update the key_ack model.
    task automatic tick();
        logic [3:0] en;
        @(posedge clk);
        #1;
        en = {sub_bytes_enable, shift_rows_enable, mix_cols_enable, add_round_key_enable};
        if (en != 4'b0000) begin
            check("round_enables", {124'd0, en}, {124'd0, exp_en[key_round]});
            check("enable_with_key_req", {127'd0, key_req}, 128'd0);
            ena_cycles++;
        end
        if (key_req) kreq_cycles++;
        if (done) done_seen++;
        if (cur_delay == 0) begin
            key_ack = 1'b1;
        end else if (key_req) begin
            key_ack = (wait_cnt >= cur_delay);
            wait_cnt++;
        end else begin
            key_ack  = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic begin_run(input int idx);
        expand_key(vecs[idx].key);
        data_in     = vecs[idx].pt;
        cur_delay   = vecs[idx].delay;
        wait_cnt    = 0;
        key_ack     = (cur_delay == 0);
        ena_cycles  = 0;
        kreq_cycles = 0;
        done_seen   = 0;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        int cyc;
        begin_run(idx);
        cyc = 1;
        while (cyc < 300) begin
            start = vecs[idx].repulse && (cyc == 5 || cyc == 12 || cyc == 24);
            if (done) break;
            tick();
            cyc++;
        end
        check("latency", 128'(cyc), 128'(vecs[idx].lat));
        check("cipher_out", cipher_out, vecs[idx].ct);
        check("key_req_cycles", 128'(kreq_cycles), 128'(11 * (vecs[idx].delay + 1)));
        tick();
        start = 1'b0;
        check("done_after", {127'd0, done}, 128'd0);
        check("busy_after", {127'd0, busy}, 128'd0);
        check("cipher_held", cipher_out, vecs[idx].ct);
        tick();
        tick();
        check("done_count", 128'(done_seen), 128'd1);
        check("round_cycles", 128'(ena_cycles), 128'd11);
        check("idle_after", {127'd0, busy}, 128'd0);
    endtask

    task automatic run_to_round(input logic [3:0] r);
        int guard;
        guard = 0;
        while (!(add_round_key_enable && key_round == r) && guard < 300) begin
            tick();
            guard++;
        end
        check("reached_round", 128'(guard < 300), 128'd1);
    endtask

    initial begin
        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 0, 24, 1'b0};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 3, 57, 1'b0};
        vecs[2] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 35, 1'b0};
        vecs[3] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 0, 24, 1'b1};
        for (int r = 0; r < 16; r++) exp_en[r] = 4'b0000;
        exp_en[0] = 4'b0001;
        for (int r = 1; r < 10; r++) exp_en[r] = 4'b1111;
        exp_en[10] = 4'b1101;
        for (int r = 0; r < 16; r++) rk[r] = 128'd0;

        n_rst   = 1'b0;
        start   = 1'b0;
        key_ack = 1'b0;
        data_in = 128'd0;
`ifdef AES_ENC_ABORT_EN
        abort   = 1'b0;
`endif
        #22;
        check("reset_outputs", {key_req, key_round, busy, done, sub_bytes_enable, shift_rows_enable,
                                mix_cols_enable, add_round_key_enable}, 128'd0);
        check("reset_state_out", state_out, 128'd0);
        check("reset_cipher_out", cipher_out, 128'd0);
        tick();
        n_rst = 1'b1;
        tick();
        check("idle_busy", {127'd0, busy}, 128'd0);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Reset in the middle of round 5 must clear every output immediately.
        begin_run(0);
        run_to_round(4'd5);
        n_rst = 1'b0;
        #1;
        check("midreset_ctrl", {key_req, key_round, busy, done, sub_bytes_enable, shift_rows_enable,
                                mix_cols_enable, add_round_key_enable}, 128'd0);
        check("midreset_state_out", state_out, 128'd0);
        check("midreset_cipher_out", cipher_out, 128'd0);
        tick();
        n_rst = 1'b1;
        tick();
        run_vec(0);

`ifdef AES_ENC_ABORT_EN
        begin
            logic [127:0] prev;
            prev = cipher_out;
            begin_run(2);
            run_to_round(4'd3);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("aborted_pulse", {127'd0, aborted}, 128'd1);
            check("abort_busy", {127'd0, busy}, 128'd0);
            check("abort_cipher_kept", cipher_out, prev);
            tick();
            check("aborted_clear", {127'd0, aborted}, 128'd0);
            check("abort_no_done", 128'(done_seen), 128'd0);
            check("abort_state_cleared", state_out, 128'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
